// File: rtl/regfile16x16_pkg.sv
// Shared sizing and reset constants for the 16x16 register file.
package regfile16x16_pkg;

  localparam int unsigned REG_W   = 16;
  localparam int unsigned REG_CNT = 16;
  localparam int unsigned ADDR_W  = 4;
  localparam int unsigned R4_IDX  = 4;
  localparam logic [REG_W-1:0] R4_RESET = 16'h0003;

endpackage

// File: rtl/regfile16x16_if.sv
// Register-file access bus: two read ports (A, B) and one write port (C).
interface regfile16x16_if
  import regfile16x16_pkg::*;
#(
  parameter int unsigned WIDTH = REG_W
);

  logic [ADDR_W-1:0] Aaddr;
  logic [ADDR_W-1:0] Baddr;
  logic [ADDR_W-1:0] Caddr;
  logic [WIDTH-1:0]  C;
  logic              Load;
  logic [WIDTH-1:0]  A;
  logic [WIDTH-1:0]  B;

  modport master (
    output Aaddr, Baddr, Caddr, C, Load,
    input  A, B
  );

  modport slave (
    input  Aaddr, Baddr, Caddr, C, Load,
    output A, B
  );

endinterface

// File: rtl/regfile_read_mux.sv
// 16:1 combinational read select, one per read port.
module regfile_read_mux
  import regfile16x16_pkg::*;
#(
  parameter int unsigned WIDTH = REG_W
) (
  input  logic [REG_CNT-1:0][WIDTH-1:0] d,
  input  logic [ADDR_W-1:0]             sel,
  output logic [WIDTH-1:0]              q
);

  always_comb begin
    q = d[sel];
  end

endmodule

// File: rtl/regfile16x16.sv
// 16 x WIDTH register file: two combinational read ports, one synchronous write port,
// asynchronous Clear with R4 resetting to a non-zero constant.
module regfile16x16
  import regfile16x16_pkg::*;
#(
  parameter int unsigned      WIDTH    = REG_W,
  parameter logic [WIDTH-1:0] R4_RESET = WIDTH'(regfile16x16_pkg::R4_RESET)
) (
  input  logic          clk,
  input  logic          Clear,
  regfile16x16_if.slave rf
);

  logic [REG_CNT-1:0][WIDTH-1:0] regs;
  logic [REG_CNT-1:0][WIDTH-1:0] regs_nxt;
  logic [REG_CNT-1:0]            wsel;

  always_comb begin
    wsel = '0;
    if (rf.Load) begin
      wsel[rf.Caddr] = 1'b1;
    end
  end

  always_comb begin
    regs_nxt = regs;
    for (int unsigned i = 0; i < REG_CNT; i++) begin
      regs_nxt[i] = wsel[i] ? rf.C : regs[i];
    end
  end

  always_ff @(posedge clk or posedge Clear) begin
    if (Clear) begin
      for (int unsigned i = 0; i < REG_CNT; i++) begin
        regs[i] <= (i == R4_IDX) ? R4_RESET : '0;
      end
    end else begin
      regs <= regs_nxt;
    end
  end

  // No write bypass: reads see stored contents, so a same-cycle write shows after the edge.
  regfile_read_mux #(.WIDTH(WIDTH)) u_mux_a (
    .d   (regs),
    .sel (rf.Aaddr),
    .q   (rf.A)
  );

  regfile_read_mux #(.WIDTH(WIDTH)) u_mux_b (
    .d   (regs),
    .sel (rf.Baddr),
    .q   (rf.B)
  );

endmodule

// File: tb/tb_regfile16x16.sv
// Self-checking bench for regfile16x16: expected read values are queued from a bench
// model when addresses are driven and popped when the read ports settle.
module tb_regfile16x16;

  typedef struct {
    logic        is_b;
    logic [3:0]  addr;
    logic [15:0] exp;
  } exp_t;

  logic clk = 1'b0;
  logic Clear = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;
  exp_t sbq[$];
  logic [15:0] mdl [16];

  regfile16x16_if #(.WIDTH(16)) rf ();

  regfile16x16 #(.WIDTH(16), .R4_RESET(16'h0003)) dut (
    .clk   (clk),
    .Clear (Clear),
    .rf    (rf)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    for (int i = 0; i < 16; i++) mdl[i] = 16'h0000;
    mdl[4] = 16'h0003;
  endtask

  task automatic do_write(input logic [3:0] a, input logic [15:0] d, input logic ld);
    @(negedge clk);
    rf.Caddr = a;
    rf.C     = d;
    rf.Load  = ld;
    @(posedge clk);
    #1;
    rf.Load = 1'b0;
    if (ld) mdl[a] = d;
  endtask

  // Queue expectations for a read pair and drive the addresses.
  task automatic drive_read(input logic [3:0] a, input logic [3:0] b);
    sbq.push_back('{is_b: 1'b0, addr: a, exp: mdl[a]});
    sbq.push_back('{is_b: 1'b1, addr: b, exp: mdl[b]});
    rf.Aaddr = a;
    rf.Baddr = b;
  endtask

  task automatic test_reset();
    exp_t e;
    logic [15:0] obs;
    rf.Load = 1'b0; rf.Caddr = '0; rf.C = '0; rf.Aaddr = '0; rf.Baddr = '0;
    #2;
    Clear = 1'b1;
    #1;
    rf.Aaddr = 4'd4;
    rf.Baddr = 4'd0;
    #1;
    n_checks++;
    if (rf.A !== 16'h0003) begin
      n_fail++;
      $display("FAIL reset_pre_edge_A: got %h, required %h", rf.A, 16'h0003);
    end
    n_checks++;
    if (rf.B !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_pre_edge_B: got %h, required %h", rf.B, 16'h0000);
    end
    model_reset();
    for (int a = 0; a < 16; a++) begin
      drive_read(4'(a), 4'(15 - a));
      #1;
      repeat (2) begin
        e = sbq.pop_front();
        obs = e.is_b ? rf.B : rf.A;
        n_checks++;
        if (obs !== e.exp) begin
          n_fail++;
          $display("FAIL reset_sweep port=%s addr=%0d: got %h, required %h",
                   e.is_b ? "B" : "A", e.addr, obs, e.exp);
        end
      end
    end
    @(negedge clk);
    Clear = 1'b0;
  endtask

  task automatic test_write();
    exp_t e;
    logic [15:0] obs;
    do_write(4'd7, 16'hBEEF, 1'b1);
    drive_read(4'd7, 4'd7);
    #1;
    repeat (2) begin
      e = sbq.pop_front();
      obs = e.is_b ? rf.B : rf.A;
      n_checks++;
      if (obs !== e.exp || obs !== 16'hBEEF) begin
        n_fail++;
        $display("FAIL write_r7 port=%s: got %h, required %h", e.is_b ? "B" : "A", obs, 16'hBEEF);
      end
    end
    drive_read(4'd6, 4'd8);
    #1;
    repeat (2) begin
      e = sbq.pop_front();
      obs = e.is_b ? rf.B : rf.A;
      n_checks++;
      if (obs !== e.exp) begin
        n_fail++;
        $display("FAIL write_neighbour addr=%0d: got %h, required %h", e.addr, obs, e.exp);
      end
    end
  endtask

  task automatic test_no_load();
    exp_t e;
    logic [15:0] obs;
    repeat (3) do_write(4'd2, 16'h1234, 1'b0);
    drive_read(4'd2, 4'd7);
    #1;
    repeat (2) begin
      e = sbq.pop_front();
      obs = e.is_b ? rf.B : rf.A;
      n_checks++;
      if (obs !== e.exp) begin
        n_fail++;
        $display("FAIL no_load addr=%0d: got %h, required %h", e.addr, obs, e.exp);
      end
    end
  endtask

  task automatic test_read_during_write();
    exp_t e;
    logic [15:0] obs;
    @(negedge clk);
    rf.Caddr = 4'd5;
    rf.C     = 16'h00A5;
    rf.Load  = 1'b1;
    drive_read(4'd5, 4'd5);
    #1;
    repeat (2) begin
      e = sbq.pop_front();
      obs = e.is_b ? rf.B : rf.A;
      n_checks++;
      if (obs !== e.exp) begin
        n_fail++;
        $display("FAIL rdw_before_edge port=%s: got %h, required %h", e.is_b ? "B" : "A", obs, e.exp);
      end
    end
    @(posedge clk);
    #1;
    rf.Load = 1'b0;
    mdl[5] = 16'h00A5;
    drive_read(4'd5, 4'd5);
    #1;
    repeat (2) begin
      e = sbq.pop_front();
      obs = e.is_b ? rf.B : rf.A;
      n_checks++;
      if (obs !== e.exp) begin
        n_fail++;
        $display("FAIL rdw_after_edge port=%s: got %h, required %h", e.is_b ? "B" : "A", obs, e.exp);
      end
    end
  endtask

  task automatic test_extremes();
    exp_t e;
    logic [15:0] obs;
    do_write(4'd15, 16'hFFFF, 1'b1);
    do_write(4'd0, 16'h0001, 1'b1);
    drive_read(4'd15, 4'd0);
    #1;
    repeat (2) begin
      e = sbq.pop_front();
      obs = e.is_b ? rf.B : rf.A;
      n_checks++;
      if (obs !== e.exp) begin
        n_fail++;
        $display("FAIL extremes addr=%0d: got %h, required %h", e.addr, obs, e.exp);
      end
    end
  endtask

  task automatic test_clear_priority();
    exp_t e;
    logic [15:0] obs;
    @(negedge clk);
    rf.Caddr = 4'd4;
    rf.C     = 16'h5555;
    rf.Load  = 1'b1;
    #1;
    Clear = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    drive_read(4'd4, 4'd7);
    #1;
    repeat (2) begin
      e = sbq.pop_front();
      obs = e.is_b ? rf.B : rf.A;
      n_checks++;
      if (obs !== e.exp) begin
        n_fail++;
        $display("FAIL clear_priority addr=%0d: got %h, required %h", e.addr, obs, e.exp);
      end
    end
    @(negedge clk);
    Clear = 1'b0;
    @(posedge clk);
    #1;
    rf.Load = 1'b0;
    mdl[4] = 16'h5555;
    drive_read(4'd4, 4'd15);
    #1;
    repeat (2) begin
      e = sbq.pop_front();
      obs = e.is_b ? rf.B : rf.A;
      n_checks++;
      if (obs !== e.exp) begin
        n_fail++;
        $display("FAIL clear_release_write addr=%0d: got %h, required %h", e.addr, obs, e.exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    logic [15:0] obs;
    @(negedge clk);
    for (int k = 0; k < 40; k++) begin
      rf.Caddr = 4'($urandom_range(15));
      rf.C     = 16'($urandom);
      rf.Load  = 1'($urandom_range(3) != 0);
      @(posedge clk);
      #1;
      if (rf.Load) mdl[rf.Caddr] = rf.C;
      @(negedge clk);
    end
    rf.Load = 1'b0;
    for (int a = 0; a < 16; a++) begin
      drive_read(4'(a), 4'($urandom_range(15)));
      #1;
      repeat (2) begin
        e = sbq.pop_front();
        obs = e.is_b ? rf.B : rf.A;
        n_checks++;
        if (obs !== e.exp) begin
          n_fail++;
          $display("FAIL back_to_back port=%s addr=%0d: got %h, required %h",
                   e.is_b ? "B" : "A", e.addr, obs, e.exp);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_no_load();
    test_read_during_write();
    test_extremes();
    test_clear_priority();
    test_back_to_back();
    if (sbq.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d entries left, required 0", sbq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
